// File: rtl/mem_sink.sv
// mem_sink: arms on start, captures up to DATANUM words into a RAM by arrival order.
// Optional running sum of stored words when MEM_SINK_SUM_EN is defined.
module mem_sink #(
  parameter int DATA_W  = 16,
  parameter int DATANUM = 64,
  parameter int ADR_W   = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              start,
  input  logic              vi,
  input  logic              fi,
  input  logic [DATA_W-1:0] di,
  input  logic [ADR_W-1:0]  rd_adr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              tout,
  output logic [ADR_W-1:0]  cnt
`ifdef MEM_SINK_SUM_EN
  ,
  output logic [DATA_W+ADR_W-1:0] sum
`endif
);

  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DEPTH = 1 << ADR_W;

  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [ADR_W-1:0] NLAST = ADR_W'(DATANUM);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [ADR_W-1:0] cnt_nx;
  logic             wen;
  logic             arm;
  logic             tmo;

  logic [DATA_W-1:0] mem [DEPTH];

  assign cnt_nx = cnt + ADR_W'(1);
  assign tmo    = (timer == TLAST);
  assign arm    = start && (state == IDLE || state == DONE);
  assign wen    = vi && (state == WAIT || state == CAPTURE)
               && (cnt < NLAST);

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state <= IDLE;
      timer <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      tout  <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT;
            busy  <= 1'b1;
            done  <= 1'b0;
            ovf   <= 1'b0;
            tout  <= 1'b0;
            cnt   <= '0;
            timer <= '0;
          end
        end
        WAIT: begin
          if (vi) begin
            cnt   <= ADR_W'(1);
            timer <= '0;
            if (DATANUM == 1 || fi) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end else if (fi) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            timer <= '0;
          end else if (tmo) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            tout  <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CAPTURE: begin
          if (vi) begin
            cnt   <= cnt_nx;
            timer <= '0;
            if (cnt_nx == NLAST || fi) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (fi) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            timer <= '0;
          end else if (tmo) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            tout  <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          // a restart in the same cycle as a stray word wins and clears ovf
          if (start) begin
            state <= WAIT;
            busy  <= 1'b1;
            done  <= 1'b0;
            ovf   <= 1'b0;
            tout  <= 1'b0;
            cnt   <= '0;
            timer <= '0;
          end else if (vi) begin
            ovf <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[cnt] <= di;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_adr];
    end
  end

`ifdef MEM_SINK_SUM_EN
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      sum <= '0;
    end else if (arm) begin
      sum <= '0;
    end else if (wen) begin
      sum <= sum + {{ADR_W{1'b0}}, di};
    end
  end
`else
  logic unused_arm;
  assign unused_arm = arm;
`endif

endmodule

// File: tb/tb_mem_sink.sv
// Directed self-checking bench for mem_sink (DATANUM=8, TIMEOUT=16).
// Covers full run, readback, overflow, restart, early finish, timeout, gaps, reset.
module tb_mem_sink;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_x;
  logic          start;
  logic          vi;
  logic          fi;
  logic [DW-1:0] di;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          tout;
  logic [AW-1:0] cnt;
`ifdef MEM_SINK_SUM_EN
  logic [DW+AW-1:0] sum;
`endif

  int checks   = 0;
  int failures = 0;

  mem_sink #(
    .DATA_W (DW),
    .DATANUM(8),
    .ADR_W  (AW),
    .TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .reset_x(reset_x),
    .start  (start),
    .vi     (vi),
    .fi     (fi),
    .di     (di),
    .rd_adr (rd_adr),
    .rd_data(rd_data),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .tout   (tout),
    .cnt    (cnt)
`ifdef MEM_SINK_SUM_EN
    ,
    .sum    (sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int acc;
    reset_x = 1'b0;
    start   = 1'b0;
    vi      = 1'b0;
    fi      = 1'b0;
    di      = '0;
    rd_adr  = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_tout", 32'(tout), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_rd", 32'(rd_data), 0);

    // full run of 8 back-to-back words
    reset_x = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    chk("arm_done", 32'(done), 0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      vi = 1'b1;
      di = DW'(16 + i);
      acc += 16 + i;
      step();
      chk("full_cnt", 32'(cnt), 32'(i + 1));
      chk("full_done", 32'(done), (i == 7) ? 1 : 0);
    end
    vi = 1'b0;
    chk("full_busy", 32'(busy), 0);
    chk("full_ovf", 32'(ovf), 0);
`ifdef MEM_SINK_SUM_EN
    chk("full_sum", 32'(sum), 32'(acc));
    chk("full_sum_k", 32'(sum), 32'h9C);
`endif
    for (int i = 0; i < 8; i++) begin
      rd_adr = AW'(i);
      step();
      chk("full_rd", 32'(rd_data), 32'(16 + i));
    end

    // overflow in DONE: flagged, not stored
    vi = 1'b1;
    di = 16'h00FF;
    rd_adr = 4'd7;
    step();
    vi = 1'b0;
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_done", 32'(done), 1);
    chk("ovf_cnt", 32'(cnt), 8);
    rd_adr = 4'd0;
    step();
    chk("ovf_rd0", 32'(rd_data), 32'h10);
    rd_adr = 4'd7;
    step();
    chk("ovf_rd7", 32'(rd_data), 32'h17);
`ifdef MEM_SINK_SUM_EN
    chk("ovf_sum", 32'(sum), 32'h9C);
`endif

    // restart without reset
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_ovf", 32'(ovf), 0);
    chk("rs_done", 32'(done), 0);
    chk("rs_cnt", 32'(cnt), 0);
    chk("rs_busy", 32'(busy), 1);
`ifdef MEM_SINK_SUM_EN
    chk("rs_sum", 32'(sum), 0);
`endif

    // early finish with fi on the 3rd word
    vi = 1'b1;
    di = 16'h000A;
    step();
    di = 16'h000B;
    step();
    di = 16'h000C;
    fi = 1'b1;
    step();
    vi = 1'b0;
    fi = 1'b0;
    chk("ef_done", 32'(done), 1);
    chk("ef_cnt", 32'(cnt), 3);
    chk("ef_ovf", 32'(ovf), 0);
    chk("ef_busy", 32'(busy), 0);
    rd_adr = 4'd2;
    step();
    chk("ef_rd2", 32'(rd_data), 32'hC);
    rd_adr = 4'd3;
    step();
    chk("ef_rd3", 32'(rd_data), 32'h13);
`ifdef MEM_SINK_SUM_EN
    chk("ef_sum", 32'(sum), 32'h21);
`endif

    // timeout: no words after start
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_busy", 32'(busy), 1);
    for (int i = 0; i < 15; i++) step();
    chk("to_early", 32'(tout), 0);
    chk("to_early_d", 32'(done), 0);
    step();
    chk("to_tout", 32'(tout), 1);
    chk("to_done", 32'(done), 1);
    chk("to_cnt", 32'(cnt), 0);
    chk("to_busy0", 32'(busy), 0);

    // gapped stream, then reset after the 4th word
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vi = 1'b1;
      di = DW'(48 + k);
      step();
      vi = 1'b0;
      for (int g = 0; g < 5; g++) step();
    end
    chk("gap_tout", 32'(tout), 0);
    chk("gap_busy", 32'(busy), 1);
    chk("gap_cnt", 32'(cnt), 3);
    vi = 1'b1;
    di = 16'h0033;
    step();
    vi = 1'b0;
    chk("gap_cnt4", 32'(cnt), 4);
    rd_adr  = 4'd3;
    reset_x = 1'b0;
    step();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_cnt", 32'(cnt), 0);
    chk("mr_tout", 32'(tout), 0);
    chk("mr_ovf", 32'(ovf), 0);
    chk("mr_rd", 32'(rd_data), 0);
`ifdef MEM_SINK_SUM_EN
    chk("mr_sum", 32'(sum), 0);
`endif

    // vi in IDLE is ignored, then fi alone in WAIT finishes empty
    reset_x = 1'b1;
    vi = 1'b1;
    di = 16'h0077;
    step();
    vi = 1'b0;
    chk("idle_cnt", 32'(cnt), 0);
    chk("idle_ovf", 32'(ovf), 0);
    chk("idle_rd3", 32'(rd_data), 32'h33);
    start = 1'b1;
    step();
    start = 1'b0;
    fi = 1'b1;
    step();
    fi = 1'b0;
    chk("fw_done", 32'(done), 1);
    chk("fw_cnt", 32'(cnt), 0);
    chk("fw_tout", 32'(tout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
